pci_irq_requester: RTL and testbench

Initiator side of the toggle-based PCI interrupt handshake. It latches rising edges from NUM_SRC local interrupt sources and arbitrates among them round-robin. For each winning source it signals the bridge by toggling IRQ_REQ with IRQ_VECTOR held stable, then waits for the single-cycle IRQ_ACK pulse. If no ACK arrives it times out and retries by toggling again. It sits between user-logic interrupt sources and the PCI bridge.

---
 rtl/pci_irq_pkg.sv | 31 +++
 rtl/pci_irq_rr_arbiter.sv | 35 +++
 rtl/pci_irq_requester.sv | 136 +++++++++++++
 tb/tb_pci_irq_requester.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_irq_pkg.sv
// Shared types and helpers for the toggle-handshake PCI interrupt requester.
package pci_irq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } irq_state_e;

  localparam int DEF_TIMEOUT = 64;
  localparam int MAX_SRC     = 16;

  // First set bit of eligible at or after ptr, wrapping at num_src; 0 when none.
  function automatic logic [3:0] rr_pick(input logic [MAX_SRC-1:0] eligible,
                                         input logic [3:0]         ptr,
                                         input int                 num_src);
    logic [3:0] pick;
    int         idx;
    pick = '0;
    for (int k = MAX_SRC - 1; k >= 0; k--) begin
      if (k < num_src) begin
        idx = int'(ptr) + k;
        if (idx >= num_src) idx = idx - num_src;
        if (eligible[idx[3:0]]) pick = idx[3:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pci_irq_rr_arbiter.sv
// Round-robin pick among eligible sources; pointer moves past the winner on issue.
module pci_irq_rr_arbiter
  import pci_irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int VEC_W   = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_SRC-1:0] i_eligible,
  input  logic               i_advance,
  output logic               o_any,
  output logic [VEC_W-1:0]   o_winner
);

  logic [VEC_W-1:0]   r_ptr;
  logic [MAX_SRC-1:0] w_elig_ext;
  logic [3:0]         w_ptr_ext;
  logic [3:0]         w_pick;

  assign w_elig_ext = MAX_SRC'(i_eligible);
  assign w_ptr_ext  = 4'(r_ptr);
  assign w_pick     = rr_pick(w_elig_ext, w_ptr_ext, NUM_SRC);
  assign o_any      = |i_eligible;
  assign o_winner   = VEC_W'(w_pick);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_winner == VEC_W'(NUM_SRC - 1)) ? '0 : o_winner + 1'b1;
    end
  end

endmodule

// File: rtl/pci_irq_requester.sv
// Initiator side of the toggle-based PCI interrupt handshake: edge latch,
// round-robin issue, ACK wait with timeout and bounded retry.
//
// state    | meaning
// IDLE     | waiting for an eligible pending source; loads IRQ_VECTOR
// ISSUE    | toggles IRQ_REQ, arms timeout and retry counters
// WAIT_ACK | counts down for IRQ_ACK; retoggles on expiry until retries run out
// GAP      | one idle cycle between requests
module pci_irq_requester
  import pci_irq_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int VEC_W     = 2,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_mask,
  output logic               IRQ_REQ,
  output logic [VEC_W-1:0]   IRQ_VECTOR,
  input  logic               IRQ_ACK,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy,
  output logic               timeout_err,
  output logic               spurious_ack
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  irq_state_e         r_state, w_state_nxt;
  logic [NUM_SRC-1:0] r_src_q, r_pending;
  logic [NUM_SRC-1:0] w_rise, w_eligible, w_clear;
  logic               r_req, w_req_nxt;
  logic [VEC_W-1:0]   r_vec, w_vec_nxt;
  logic [TW-1:0]      r_tmo, w_tmo_nxt;
  logic [RW-1:0]      r_retry, w_retry_nxt;
  logic               r_timeout_err, r_spurious;
  logic               w_issue, w_abandon, w_any;
  logic [VEC_W-1:0]   w_winner;

  assign w_rise     = irq_src & ~r_src_q;
  assign w_eligible = r_pending & ~irq_mask;

  pci_irq_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .VEC_W   (VEC_W)
  ) u_arb (
    .clk        (clk),
    .resetn     (resetn),
    .i_eligible (w_eligible),
    .i_advance  (w_issue),
    .o_any      (w_any),
    .o_winner   (w_winner)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_vec_nxt   = r_vec;
    w_tmo_nxt   = r_tmo;
    w_retry_nxt = r_retry;
    w_clear     = '0;
    w_issue     = 1'b0;
    w_abandon   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_issue     = 1'b1;
          w_vec_nxt   = w_winner;
          w_clear     = NUM_SRC'(1) << w_winner;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_req_nxt   = ~r_req;
        w_tmo_nxt   = TW'(TIMEOUT);
        w_retry_nxt = '0;
        w_state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        // ACK wins over a timeout expiring in the same cycle
        if (IRQ_ACK) begin
          w_state_nxt = GAP;
        end else if (r_tmo == TW'(1)) begin
          if (r_retry < RW'(MAX_RETRY)) begin
            w_req_nxt   = ~r_req;
            w_retry_nxt = r_retry + 1'b1;
            w_tmo_nxt   = TW'(TIMEOUT);
          end else begin
            w_abandon   = 1'b1;
            w_state_nxt = GAP;
          end
        end else if (r_tmo != '0) begin
          w_tmo_nxt = r_tmo - 1'b1;
        end
      end
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_src_q       <= '0;
      r_pending     <= '0;
      r_req         <= 1'b0;
      r_vec         <= '0;
      r_tmo         <= '0;
      r_retry       <= '0;
      r_timeout_err <= 1'b0;
      r_spurious    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_src_q       <= irq_src;
      r_pending     <= (r_pending & ~w_clear) | w_rise;
      r_req         <= w_req_nxt;
      r_vec         <= w_vec_nxt;
      r_tmo         <= w_tmo_nxt;
      r_retry       <= w_retry_nxt;
      r_timeout_err <= w_abandon;
      r_spurious    <= IRQ_ACK && (r_state != WAIT_ACK);
    end
  end

  assign IRQ_REQ      = r_req;
  assign IRQ_VECTOR   = r_vec;
  assign pending      = r_pending;
  assign busy         = (r_state == ISSUE) || (r_state == WAIT_ACK);
  assign timeout_err  = r_timeout_err;
  assign spurious_ack = r_spurious;

endmodule

// File: tb/tb_pci_irq_requester.sv
// Directed bench for pci_irq_requester: issue, round-robin, retry, mask, reset, spurious ACK.
module tb_pci_irq_requester;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] irq_src;
  logic [3:0] irq_mask;
  logic       IRQ_REQ;
  logic [1:0] IRQ_VECTOR;
  logic       IRQ_ACK;
  logic [3:0] pending;
  logic       busy;
  logic       timeout_err;
  logic       spurious_ack;

  always #5 clk = ~clk;

  pci_irq_requester #(
    .NUM_SRC   (4),
    .VEC_W     (2),
    .TIMEOUT   (64),
    .MAX_RETRY (3)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .irq_src      (irq_src),
    .irq_mask     (irq_mask),
    .IRQ_REQ      (IRQ_REQ),
    .IRQ_VECTOR   (IRQ_VECTOR),
    .IRQ_ACK      (IRQ_ACK),
    .pending      (pending),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .spurious_ack (spurious_ack)
  );

  int   n_tests   = 0;
  int   n_fail    = 0;
  int   n_toggle  = 0;
  int   n_tmo_err = 0;
  int   n_spur    = 0;
  logic last_req  = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; samples 1 ns after the edge and tallies toggles/pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (resetn && (IRQ_REQ != last_req)) n_toggle++;
    last_req = IRQ_REQ;
    if (timeout_err)  n_tmo_err++;
    if (spurious_ack) n_spur++;
  endtask

  task automatic do_reset();
    irq_src  = '0;
    irq_mask = '0;
    IRQ_ACK  = 1'b0;
    resetn   = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic wait_toggle(input int budget, output int cycles);
    int start;
    start  = n_toggle;
    cycles = 0;
    while ((n_toggle == start) && (cycles < budget)) begin
      tick();
      cycles++;
    end
    chk("toggle_seen", n_toggle - start, 1);
  endtask

  // ACK sampled by the DUT on the d-th edge after the toggle edge.
  task automatic ack_after(input int d);
    repeat (d - 1) tick();
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base;
    int base_err;
    int base_sp;
    int exp_vec[3];
    exp_vec = '{0, 1, 3};

    resetn   = 1'b0;
    irq_src  = '0;
    irq_mask = '0;
    IRQ_ACK  = 1'b0;
    do_reset();
    chk("rst_req",  int'(IRQ_REQ), 0);
    chk("rst_vec",  int'(IRQ_VECTOR), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_terr", int'(timeout_err), 0);
    chk("rst_spur", int'(spurious_ack), 0);

    // single request on source 2
    irq_src = 4'b0100;
    tick();
    chk("t1_pend",  int'(pending), 4);
    chk("t1_idle",  int'(busy), 0);
    tick();
    chk("t1_busy",  int'(busy), 1);
    chk("t1_vec",   int'(IRQ_VECTOR), 2);
    chk("t1_clr",   int'(pending), 0);
    chk("t1_req0",  int'(IRQ_REQ), 0);
    wait_toggle(5, n);
    chk("t1_lat",   n, 1);
    chk("t1_req1",  int'(IRQ_REQ), 1);
    ack_after(4);
    chk("t1_done",  int'(busy), 0);
    chk("t1_vec_h", int'(IRQ_VECTOR), 2);
    repeat (5) tick();
    chk("t1_req_h", int'(IRQ_REQ), 1);
    chk("t1_tgl",   n_toggle, 1);
    chk("t1_terr",  n_tmo_err, 0);

    // round-robin 0,1,3 from a fresh pointer
    do_reset();
    base = n_toggle;
    irq_src = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      wait_toggle(8, n);
      chk("rr_gap", n, 3);
      chk("rr_vec", int'(IRQ_VECTOR), exp_vec[i]);
      ack_after(4);
    end
    repeat (4) tick();
    chk("rr_tgl",  n_toggle - base, 3);
    chk("rr_pend", int'(pending), 0);
    chk("rr_busy", int'(busy), 0);
    chk("rr_req",  int'(IRQ_REQ), 1);

    // no ACK at all: 4 toggles then abandon
    do_reset();
    base     = n_toggle;
    base_err = n_tmo_err;
    irq_src  = 4'b0001;
    wait_toggle(5, n);
    chk("to_lat", n, 3);
    for (int i = 0; i < 3; i++) begin
      wait_toggle(80, n);
      chk("to_retry_gap", n, 64);
    end
    repeat (63) tick();
    chk("to_busy_pre", int'(busy), 1);
    chk("to_err_pre",  int'(timeout_err), 0);
    tick();
    chk("to_err",      int'(timeout_err), 1);
    chk("to_busy_end", int'(busy), 0);
    tick();
    chk("to_err_1cyc", int'(timeout_err), 0);
    chk("to_tgl",      n_toggle - base, 4);
    chk("to_err_cnt",  n_tmo_err - base_err, 1);
    chk("to_req",      int'(IRQ_REQ), 0);
    irq_src = 4'b0011;
    wait_toggle(6, n);
    chk("to_idle_lat", n, 3);
    chk("to_idle_vec", int'(IRQ_VECTOR), 1);
    ack_after(2);

    // ACK 10 cycles after the second toggle
    do_reset();
    base     = n_toggle;
    base_err = n_tmo_err;
    irq_src  = 4'b0010;
    wait_toggle(5, n);
    wait_toggle(80, n);
    chk("rs_gap", n, 64);
    ack_after(10);
    chk("rs_busy", int'(busy), 0);
    repeat (150) tick();
    chk("rs_tgl", n_toggle - base, 2);
    chk("rs_err", n_tmo_err - base_err, 0);
    chk("rs_req", int'(IRQ_REQ), 0);

    // masked source latches; unmask coincides with a new rise on it
    do_reset();
    base     = n_toggle;
    irq_mask = 4'b0010;
    irq_src  = 4'b0010;
    repeat (6) tick();
    chk("mk_pend", int'(pending), 2);
    chk("mk_tgl",  n_toggle - base, 0);
    chk("mk_busy", int'(busy), 0);
    irq_src = 4'b0000;
    tick();
    irq_mask = 4'b0000;
    irq_src  = 4'b0010;
    tick();
    chk("col_pend", int'(pending), 2);
    chk("col_busy", int'(busy), 1);
    chk("col_vec",  int'(IRQ_VECTOR), 1);
    wait_toggle(3, n);
    chk("col_lat", n, 1);
    ack_after(4);
    wait_toggle(8, n);
    chk("reiss_gap",  n, 3);
    chk("reiss_vec",  int'(IRQ_VECTOR), 1);
    chk("reiss_pend", int'(pending), 0);
    ack_after(4);
    chk("mk_tgl2", n_toggle - base, 2);

    // reset while waiting for ACK
    do_reset();
    base     = n_toggle;
    base_err = n_tmo_err;
    irq_src  = 4'b0101;
    wait_toggle(5, n);
    chk("rm_vec", int'(IRQ_VECTOR), 0);
    repeat (5) tick();
    chk("rm_pend_pre", int'(pending), 4);
    chk("rm_busy_pre", int'(busy), 1);
    irq_src = 4'b0000;
    resetn  = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rm_req",  int'(IRQ_REQ), 0);
    chk("rm_pend", int'(pending), 0);
    chk("rm_busy", int'(busy), 0);
    chk("rm_vec0", int'(IRQ_VECTOR), 0);
    repeat (80) tick();
    chk("rm_err", n_tmo_err - base_err, 0);
    chk("rm_tgl", n_toggle - base, 1);

    // ACK while idle
    base_sp = n_spur;
    IRQ_ACK = 1'b1;
    tick();
    IRQ_ACK = 1'b0;
    chk("sp_pulse", int'(spurious_ack), 1);
    chk("sp_busy",  int'(busy), 0);
    tick();
    chk("sp_1cyc",  int'(spurious_ack), 0);
    chk("sp_pend",  int'(pending), 0);
    chk("sp_req",   int'(IRQ_REQ), 0);
    chk("sp_cnt",   n_spur - base_sp, 1);
    chk("sp_total", n_spur, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
